// File: rtl/cmd_issuer.sv
// Host command FIFO feeding a register-block bus with a mandatory idle GAP between issues.
// Optional macro CMD_ISSUER_SHADOW_EN adds an 8x16 shadow array that predicts register values.
module cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_data,
    output logic [7:0]  op_code,
    output logic [7:0]  address,
    output logic [15:0] data,
    output logic        cmd_strobe,
    output logic        busy,
    output logic        exp_valid,
    output logic [15:0] exp_data,
    output logic [7:0]  err_cnt,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Request handshake: a transfer happens on a rising edge where req_valid && req_ready;
    // req_ready depends only on registered FIFO fullness, never on req_valid.
    logic          accept, push, reject, pop;
    logic          fifo_empty, fifo_full;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] wr_idx, rd_idx;

    logic [7:0]  op_mem   [DEPTH];
    logic [2:0]  addr_mem [DEPTH];
    logic [15:0] data_mem [DEPTH];

    assign wr_idx     = wr_ptr[AW-1:0];
    assign rd_idx     = rd_ptr[AW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    assign req_ready = ~fifo_full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_addr[7:3] == 5'd0);
    assign reject    = accept && (req_addr[7:3] != 5'd0);

    assign busy      = ~fifo_empty || (state_q != IDLE);
    assign dbg_state = state_q;

    // Pop uses the registered empty flag, so a fresh entry is never bypassed to the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_idx]   <= req_op;
            addr_mem[wr_idx] <= req_addr[2:0];
            data_mem[wr_idx] <= req_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (reject && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: state_d = GAP;
            GAP: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus registers are loaded only on the pop edge; every other edge returns them to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_code    <= 8'd0;
            address    <= 8'd0;
            data       <= 16'd0;
            cmd_strobe <= 1'b0;
        end else if (pop) begin
            op_code    <= op_mem[rd_idx];
            address    <= {5'd0, addr_mem[rd_idx]};
            data       <= data_mem[rd_idx];
            cmd_strobe <= 1'b1;
        end else begin
            op_code    <= 8'd0;
            address    <= 8'd0;
            data       <= 16'd0;
            cmd_strobe <= 1'b0;
        end
    end

`ifdef CMD_ISSUER_SHADOW_EN
    logic [15:0] shadow_q [8];
    logic [15:0] shadow_val;
    logic        shadow_wr;
    logic [2:0]  exp_addr_q;
    logic        exp_valid_q;

    always_comb begin
        shadow_wr  = 1'b0;
        shadow_val = 16'd0;
        if (state_q == ISSUE) begin
            case (op_code)
                8'd1: begin shadow_wr = 1'b1; shadow_val = data;        end
                8'd2: begin shadow_wr = 1'b1; shadow_val = data >> 1;   end
                8'd3: begin shadow_wr = 1'b1; shadow_val = data << 1;   end
                8'd4: begin shadow_wr = 1'b1; shadow_val = ~data;       end
                default: begin shadow_wr = 1'b0; shadow_val = 16'd0;    end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) shadow_q[i] <= 16'd0;
            exp_addr_q  <= 3'd0;
            exp_valid_q <= 1'b0;
        end else begin
            if (shadow_wr) begin
                shadow_q[address[2:0]] <= shadow_val;
                exp_addr_q             <= address[2:0];
            end
            exp_valid_q <= shadow_wr;
        end
    end

    // The prediction is read back from the array so it always reflects the stored value.
    assign exp_valid = exp_valid_q;
    assign exp_data  = exp_valid_q ? shadow_q[exp_addr_q] : 16'd0;
`else
    assign exp_valid = 1'b0;
    assign exp_data  = 16'd0;
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Scoreboard bench for cmd_issuer: issued commands are matched in order against pushed ones.
// Shadow predictions are checked when CMD_ISSUER_SHADOW_EN is defined for the build.
module tb_cmd_issuer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_op = 8'd0;
    logic [7:0]  req_addr = 8'd0;
    logic [15:0] req_data = 16'd0;
    logic [7:0]  op_code;
    logic [7:0]  address;
    logic [15:0] data;
    logic        cmd_strobe;
    logic        busy;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;

    cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .op_code(op_code), .address(address), .data(data),
        .cmd_strobe(cmd_strobe), .busy(busy),
        .exp_valid(exp_valid), .exp_data(exp_data),
        .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          exp_err = 0;
    logic        saw_full = 1'b0;
    logic        gap_pend = 1'b0;
    logic        gap_ev;
    logic [15:0] gap_ed;

    function automatic logic [16:0] model_exp(input logic [7:0] op, input logic [15:0] d);
`ifdef CMD_ISSUER_SHADOW_EN
        case (op)
            8'd1:    return {1'b1, d};
            8'd2:    return {1'b1, d >> 1};
            8'd3:    return {1'b1, d << 1};
            8'd4:    return {1'b1, ~d};
            default: return 17'd0;
        endcase
`else
        return {1'b0, 16'd0 & d} | {op[7:0] & 8'd0, 9'd0};
`endif
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        logic [16:0] m;
        if (!rst_n) begin
            gap_pend = 1'b0;
        end else if (gap_pend) begin
            check("gap_strobe", {31'd0, cmd_strobe}, 32'd0);
            check("gap_bus", {op_code, address, data}, 32'd0);
            check("gap_exp_valid", {31'd0, exp_valid}, {31'd0, gap_ev});
            check("gap_exp_data", {16'd0, exp_data}, {16'd0, gap_ed});
            gap_pend = 1'b0;
        end else if (cmd_strobe) begin
            check("strobe_has_exp", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("issue_cmd", {op_code, address, data}, e);
                m = model_exp(e[31:24], e[15:0]);
                gap_ev   = m[16];
                gap_ed   = m[15:0];
                gap_pend = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] op, input logic [7:0] addr, input logic [15:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = d;
        if (!req_ready) saw_full = 1'b1;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("push_timeout", {31'd0, req_ready}, 32'd1);
        if (addr < 8) exp_q.push_back({op, addr, d});
        else if (exp_err != 255) exp_err++;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_queue", exp_q.size(), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_err = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int strobes;
        #1;
        check("rst_op", {24'd0, op_code}, 32'd0);
        check("rst_strobe", {31'd0, cmd_strobe}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {24'd0, err_cnt}, 32'd0);
        check("rst_exp_valid", {31'd0, exp_valid}, 32'd0);
        apply_reset();

        // Single command: latency, content and the GAP that follows.
        push(8'd1, 8'd3, 16'h1234);
        @(negedge clk);
        check("lat_first_cycle", {31'd0, cmd_strobe}, 32'd0);
        @(negedge clk);
        check("lat_strobe", {31'd0, cmd_strobe}, 32'd1);
        check("lat_bus", {op_code, address, data}, 32'h0103_1234);
        @(negedge clk);
        check("after_issue_bus", {op_code, address, data, 7'd0, cmd_strobe}, 33'd0);
        wait_idle();

        // Back-to-back pushes to the same register issue two cycles apart.
        push(8'd2, 8'd0, 16'h8001);
        push(8'd3, 8'd0, 16'h8001);
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_strobe && n < 20);
        check("b2b_first", {24'd0, op_code}, 32'd2);
        @(negedge clk);
        check("b2b_gap", {31'd0, cmd_strobe}, 32'd0);
        @(negedge clk);
        check("b2b_second", {24'd0, op_code, 7'd0, cmd_strobe}, {24'd0, 8'd3, 8'd1});
        wait_idle();

        // Pass-through op codes.
        push(8'd9, 8'd1, 16'h5555);
        push(8'd0, 8'd6, 16'hABCD);
        wait_idle();

        // Burst larger than the FIFO: must stall, lose nothing, keep order.
        saw_full = 1'b0;
        for (int i = 0; i < 2 * DEPTH + 2; i++)
            push(8'($urandom_range(0, 9)), 8'($urandom_range(0, 7)), 16'($urandom_range(0, 16'hFFFF)));
        check("burst_saw_full", {31'd0, saw_full}, 32'd1);
        wait_idle();

        // Rejected addresses and saturation of the error counter.
        push(8'd1, 8'd8, 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        check("reject_one", {24'd0, err_cnt}, exp_err);
        check("reject_not_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 299; i++)
            push(8'($urandom_range(0, 9)), 8'($urandom_range(8, 255)), 16'($urandom_range(0, 16'hFFFF)));
        check("reject_sat", {24'd0, err_cnt}, exp_err);
        check("reject_sat_255", exp_err, 32'd255);
        wait_idle();

        // Reset during ISSUE with two commands still queued.
        push(8'd1, 8'd1, 16'h0001);
        push(8'd4, 8'd7, 16'h00FF);
        push(8'd1, 8'd2, 16'h2222);
        push(8'd3, 8'd5, 16'h3333);
        n = 0;
        do begin @(negedge clk); n++; end while (!(cmd_strobe && op_code == 8'd4) && n < 50);
        check("rst_mid_found", {31'd0, cmd_strobe}, 32'd1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_bus", {op_code, address, data}, 32'd0);
        check("rst_mid_strobe", {31'd0, cmd_strobe}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_err", {24'd0, err_cnt}, 32'd0);
        check("rst_mid_exp", {15'd0, exp_valid, exp_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_strobe) strobes++;
        end
        check("post_rst_strobes", strobes, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_state", {30'd0, dbg_state}, 32'd0);

        // New traffic after reset is issued normally.
        push(8'd4, 8'd7, 16'h00FF);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
